apu_interface: RTL and testbench
================================

APU_INTERFACE -- requirements
Module: apu_interface

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request buffer entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, accepted-but-unreturned request limit (power of two, >=1); TAG_W = max(1, clog2(MAX_OUTSTANDING)).
REQ-003 SHALL have parameter PERF_W, default 32, performance counter width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 n_reset  input  1  asynchronous active-low reset.
REQ-006 apu_req  input  1  core request valid.
REQ-007 apu_operands  input  3x32  core operands [2:0].
REQ-008 apu_op  input  6  core opcode.
REQ-009 apu_flags_i  input  15  core flags.
REQ-010 apu_gnt  output  1  request accepted this cycle.
REQ-011 apu_rvalid  output  1  one-cycle result pulse to core.
REQ-012 apu_result  output  32  result data.
REQ-013 apu_flags_o  output  5  result flags.
REQ-014 issue_valid / issue_ready  output / input  1 / 1  downstream issue handshake.
REQ-015 issue_op, issue_operands, issue_flags, issue_tag  output  6, 3x32, 15, TAG_W  head-entry payload.
REQ-016 cmpl_valid, cmpl_tag, cmpl_result, cmpl_flags  input  1, TAG_W, 32, 5  downstream completion.
REQ-017 busy  output  1  outstanding count nonzero.
REQ-018 protocol_err  output  1  sticky completion-protocol violation.
REQ-019 perf_req_count, perf_stall_count  output  PERF_W each  performance counters.

Function
REQ-020 apu_gnt SHALL be combinational: apu_req AND FIFO not full AND outstanding < MAX_OUTSTANDING.
REQ-021 Accept (apu_req & apu_gnt) SHALL push {op, operands, flags_i, tag}; tag SHALL be a wrapping counter modulo MAX_OUTSTANDING, incremented per accept.
REQ-022 issue_valid SHALL equal FIFO not empty; an accepted request SHALL appear on issue_valid no earlier than the next cycle; the FIFO SHALL pop on issue_valid & issue_ready.
REQ-023 Push and pop in the same cycle SHALL be legal in any occupancy, including full (pop frees the slot for the same-cycle push only if gnt evaluation already allowed it; gnt SHALL NOT depend on issue_ready).
REQ-024 Outstanding counter SHALL increment on accept, decrement on apu_rvalid, and hold on both together.
REQ-025 Expected-tag counter SHALL track the oldest outstanding tag; completions SHALL be in order.
REQ-026 A completion with cmpl_tag equal to the expected tag while outstanding > 0 SHALL register result/flags and pulse apu_rvalid exactly one cycle later; the expected tag then advances with wrap.
REQ-027 A completion with a mismatched tag or zero outstanding SHALL be dropped (no apu_rvalid, counters unchanged) and SHALL set protocol_err.
REQ-028 apu_result and apu_flags_o SHALL hold their last returned values between pulses.
REQ-029 busy SHALL equal (outstanding != 0).

Reset
REQ-030 On n_reset low, the block SHALL immediately clear FIFO, tag counters, outstanding count, protocol_err and perf counters, and drive apu_rvalid, issue_valid, apu_result and apu_flags_o to 0; in-flight requests are discarded.
REQ-031 apu_gnt SHALL be 0 while n_reset is low.

Configuration
REQ-032 Macro APU_IF_PERF_EN SHALL compile in the performance counters.
REQ-033 With APU_IF_PERF_EN defined: perf_req_count SHALL increment per accept; perf_stall_count SHALL increment each cycle with apu_req & !apu_gnt; both saturate at all-ones.
REQ-034 Without APU_IF_PERF_EN: ports SHALL remain, tied to 0, with no counter flops.

Structure
REQ-035 accelerator_pkg SHALL hold constants APU_OP_W=6, APU_FLAGS_I_W=15, APU_FLAGS_O_W=5, and typedef struct apu_req_t {op, operands, flags}.
REQ-036 Storage SHALL be a sub-module apu_req_fifo (parametrised width/depth, full/empty, first-word fall-through).

Verification
REQ-037 Single op: req op=6'h05, operands {1,2,3}, issue_ready=1 -> gnt same cycle, issue_valid next cycle with tag 0; cmpl tag 0, result 32'hCAFE -> apu_rvalid one cycle later, apu_result=32'hCAFE, busy falls.
REQ-038 Outstanding limit: MAX_OUTSTANDING=4, issue_ready=1, no completions, 5 back-to-back reqs -> 4 grants, gnt=0 on 5th, perf_stall_count increments until first rvalid.
REQ-039 FIFO full: issue_ready=0, FIFO_DEPTH=4, 6 reqs -> 4 grants; raise issue_ready -> pops in order tags 0..3.
REQ-040 Tag wrap: 9 sequential req/complete pairs, MAX_OUTSTANDING=4 -> tags 0,1,2,3,0,1,2,3,0; protocol_err stays 0.
REQ-041 Protocol error: completion tag 2 while expecting 0 -> no apu_rvalid, protocol_err=1 sticky, outstanding unchanged.
REQ-042 Reset mid-operation: n_reset low with 3 outstanding -> busy, issue_valid, apu_rvalid 0 immediately; after release, next accept gets tag 0.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared widths and request payload type for the APU request/return path.
package accelerator_pkg;
  localparam int APU_OP_W      = 6;
  localparam int APU_FLAGS_I_W = 15;
  localparam int APU_FLAGS_O_W = 5;
  localparam int APU_DATA_W    = 32;

  typedef struct packed {
    logic [APU_OP_W-1:0]             op;
    logic [2:0][APU_DATA_W-1:0]      operands;
    logic [APU_FLAGS_I_W-1:0]        flags;
  } apu_req_t;

  localparam int APU_REQ_W = $bits(apu_req_t);

  function automatic int tag_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/apu_req_fifo.sv
// First-word fall-through request buffer; head entry is visible on rdata while not empty.
module apu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; validity is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/apu_interface.sv
// Core-to-accelerator bridge: buffers requests, tags them, and returns in-order results.
// Optional performance counters are compiled in with `define APU_IF_PERF_EN.
module apu_interface
  import accelerator_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PERF_W          = 32,
  localparam int TAG_W          = tag_width(MAX_OUTSTANDING)
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      apu_req,
  input  logic [2:0][APU_DATA_W-1:0] apu_operands,
  input  logic [APU_OP_W-1:0]       apu_op,
  input  logic [APU_FLAGS_I_W-1:0]  apu_flags_i,
  output logic                      apu_gnt,
  output logic                      apu_rvalid,
  output logic [APU_DATA_W-1:0]     apu_result,
  output logic [APU_FLAGS_O_W-1:0]  apu_flags_o,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [APU_OP_W-1:0]       issue_op,
  output logic [2:0][APU_DATA_W-1:0] issue_operands,
  output logic [APU_FLAGS_I_W-1:0]  issue_flags,
  output logic [TAG_W-1:0]          issue_tag,
  input  logic                      cmpl_valid,
  input  logic [TAG_W-1:0]          cmpl_tag,
  input  logic [APU_DATA_W-1:0]     cmpl_result,
  input  logic [APU_FLAGS_O_W-1:0]  cmpl_flags,
  output logic                      busy,
  output logic                      protocol_err,
  output logic [PERF_W-1:0]         perf_req_count,
  output logic [PERF_W-1:0]         perf_stall_count
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam int ENTRY_W = APU_REQ_W + TAG_W;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (MAX_OUTSTANDING == 1) ? '0 : t + TAG_W'(1);
  endfunction

  logic [OUT_W-1:0]         r_outstanding;
  logic [TAG_W-1:0]         r_tag;
  logic [TAG_W-1:0]         r_exp_tag;
  logic                     r_rvalid;
  logic [APU_DATA_W-1:0]    r_result;
  logic [APU_FLAGS_O_W-1:0] r_flags_o;
  logic                     r_protocol_err;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_gnt;
  logic                     w_cmpl_ok;
  apu_req_t                 w_req;
  apu_req_t                 w_head;
  logic [ENTRY_W-1:0]       w_push_data;
  logic [ENTRY_W-1:0]       w_pop_data;

  assign w_gnt       = n_reset && apu_req && !w_full && (r_outstanding < MAX_OUT_C);
  assign w_req       = '{op: apu_op, operands: apu_operands, flags: apu_flags_i};
  assign w_push_data = {w_req, r_tag};

  apu_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (w_gnt),
    .wdata   (w_push_data),
    .pop     (issue_ready),
    .rdata   (w_pop_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign {w_head, issue_tag} = w_pop_data;
  assign issue_op       = w_head.op;
  assign issue_operands = w_head.operands;
  assign issue_flags    = w_head.flags;
  assign issue_valid    = !w_empty;

  // A result being pulsed this cycle is still counted, so exclude it when judging a new completion.
  assign w_cmpl_ok = cmpl_valid && (cmpl_tag == r_exp_tag) && (r_outstanding > OUT_W'(r_rvalid));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_outstanding  <= '0;
      r_tag          <= '0;
      r_exp_tag      <= '0;
      r_rvalid       <= 1'b0;
      r_result       <= '0;
      r_flags_o      <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_gnt) r_tag <= next_tag(r_tag);
      case ({w_gnt, r_rvalid})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      r_rvalid <= w_cmpl_ok;
      if (w_cmpl_ok) begin
        r_result  <= cmpl_result;
        r_flags_o <= cmpl_flags;
        r_exp_tag <= next_tag(r_exp_tag);
      end
      if (cmpl_valid && !w_cmpl_ok) r_protocol_err <= 1'b1;
    end
  end

  assign apu_gnt      = w_gnt;
  assign apu_rvalid   = r_rvalid;
  assign apu_result   = r_result;
  assign apu_flags_o  = r_flags_o;
  assign busy         = (r_outstanding != '0);
  assign protocol_err = r_protocol_err;

`ifdef APU_IF_PERF_EN
  logic [PERF_W-1:0] r_perf_req;
  logic [PERF_W-1:0] r_perf_stall;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_perf_req   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_gnt && (r_perf_req != '1))                 r_perf_req   <= r_perf_req + PERF_W'(1);
      if (apu_req && !w_gnt && (r_perf_stall != '1))   r_perf_stall <= r_perf_stall + PERF_W'(1);
    end
  end

  assign perf_req_count   = r_perf_req;
  assign perf_stall_count = r_perf_stall;
`else
  assign perf_req_count   = '0;
  assign perf_stall_count = '0;
`endif
endmodule

// File: tb/tb_apu_interface.sv
// Directed bench for apu_interface: single op, limits, tag wrap, protocol error, reset.
module tb_apu_interface;
  import accelerator_pkg::*;

  localparam int TAG_W = 2;

  logic                      clk = 1'b0;
  logic                      n_reset;
  logic                      apu_req;
  logic [2:0][31:0]          apu_operands;
  logic [5:0]                apu_op;
  logic [14:0]               apu_flags_i;
  logic                      apu_gnt;
  logic                      apu_rvalid;
  logic [31:0]               apu_result;
  logic [4:0]                apu_flags_o;
  logic                      issue_valid;
  logic                      issue_ready;
  logic [5:0]                issue_op;
  logic [2:0][31:0]          issue_operands;
  logic [14:0]               issue_flags;
  logic [TAG_W-1:0]          issue_tag;
  logic                      cmpl_valid;
  logic [TAG_W-1:0]          cmpl_tag;
  logic [31:0]               cmpl_result;
  logic [4:0]                cmpl_flags;
  logic                      busy;
  logic                      protocol_err;
  logic [31:0]               perf_req_count;
  logic [31:0]               perf_stall_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apu_interface #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(4), .PERF_W(32)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .apu_req          (apu_req),
    .apu_operands     (apu_operands),
    .apu_op           (apu_op),
    .apu_flags_i      (apu_flags_i),
    .apu_gnt          (apu_gnt),
    .apu_rvalid       (apu_rvalid),
    .apu_result       (apu_result),
    .apu_flags_o      (apu_flags_o),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_op         (issue_op),
    .issue_operands   (issue_operands),
    .issue_flags      (issue_flags),
    .issue_tag        (issue_tag),
    .cmpl_valid       (cmpl_valid),
    .cmpl_tag         (cmpl_tag),
    .cmpl_result      (cmpl_result),
    .cmpl_flags       (cmpl_flags),
    .busy             (busy),
    .protocol_err     (protocol_err),
    .perf_req_count   (perf_req_count),
    .perf_stall_count (perf_stall_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0; apu_req = 1'b1; apu_op = '0; apu_operands = '0; apu_flags_i = '0;
    issue_ready = 1'b0; cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_result = '0; cmpl_flags = '0;
    #2;
    chk("rst_gnt", 64'(apu_gnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_issue_valid", 64'(issue_valid), 64'h0);
    chk("rst_rvalid", 64'(apu_rvalid), 64'h0);
    chk("rst_result", 64'(apu_result), 64'h0);
    chk("rst_flags_o", 64'(apu_flags_o), 64'h0);
    chk("rst_protocol_err", 64'(protocol_err), 64'h0);
    chk("rst_perf_req", 64'(perf_req_count), 64'h0);
    chk("rst_perf_stall", 64'(perf_stall_count), 64'h0);
    apu_req = 1'b0;
    tick; tick;
    n_reset = 1'b1;
    tick;

    // Single operation round trip
    apu_req = 1'b1; apu_op = 6'h05; apu_operands = {32'd3, 32'd2, 32'd1};
    apu_flags_i = 15'h1234; issue_ready = 1'b1;
    #1;
    chk("t1_gnt", 64'(apu_gnt), 64'h1);
    chk("t1_issue_valid_same_cycle", 64'(issue_valid), 64'h0);
    tick;
    apu_req = 1'b0;
    chk("t1_issue_valid", 64'(issue_valid), 64'h1);
    chk("t1_issue_tag", 64'(issue_tag), 64'h0);
    chk("t1_issue_op", 64'(issue_op), 64'h05);
    chk("t1_operand0", 64'(issue_operands[0]), 64'h1);
    chk("t1_operand2", 64'(issue_operands[2]), 64'h3);
    chk("t1_issue_flags", 64'(issue_flags), 64'h1234);
    chk("t1_busy", 64'(busy), 64'h1);
    cmpl_valid = 1'b1; cmpl_tag = 2'd0; cmpl_result = 32'hCAFE; cmpl_flags = 5'h03;
    tick;
    cmpl_valid = 1'b0;
    chk("t1_rvalid", 64'(apu_rvalid), 64'h1);
    chk("t1_result", 64'(apu_result), 64'hCAFE);
    chk("t1_flags_o", 64'(apu_flags_o), 64'h03);
    chk("t1_issue_popped", 64'(issue_valid), 64'h0);
    tick;
    chk("t1_rvalid_pulse", 64'(apu_rvalid), 64'h0);
    chk("t1_busy_fall", 64'(busy), 64'h0);
    chk("t1_result_hold", 64'(apu_result), 64'hCAFE);

    // Outstanding limit: tags continue from 1
    for (int i = 0; i < 5; i++) begin
      apu_req = 1'b1; apu_op = 6'(i);
      #1;
      chk($sformatf("t2_gnt%0d", i), 64'(apu_gnt), 64'(i < 4));
      tick;
    end
    apu_req = 1'b0;
`ifdef APU_IF_PERF_EN
    chk("t2_perf_req", 64'(perf_req_count), 64'd5);
    chk("t2_perf_stall", 64'(perf_stall_count), 64'd1);
`else
    chk("t2_perf_req_tied", 64'(perf_req_count), 64'd0);
    chk("t2_perf_stall_tied", 64'(perf_stall_count), 64'd0);
`endif
    chk("t2_busy", 64'(busy), 64'h1);
    cmpl_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmpl_tag = TAG_W'((i + 1) % 4); cmpl_result = 32'h100 + 32'(i);
      tick;
      chk($sformatf("t2_rvalid%0d", i), 64'(apu_rvalid), 64'h1);
      chk($sformatf("t2_result%0d", i), 64'(apu_result), 64'h100 + 64'(i));
    end
    cmpl_valid = 1'b0;
    tick;
    chk("t2_rvalid_end", 64'(apu_rvalid), 64'h0);
    chk("t2_busy_end", 64'(busy), 64'h0);
    chk("t2_protocol_err", 64'(protocol_err), 64'h0);

    // FIFO full with issue stalled
    n_reset = 1'b0; tick; n_reset = 1'b1;
    issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apu_req = 1'b1; apu_op = 6'h10 + 6'(i);
      #1;
      chk($sformatf("t3_gnt%0d", i), 64'(apu_gnt), 64'(i < 4));
      tick;
    end
    apu_req = 1'b0;
    chk("t3_issue_valid", 64'(issue_valid), 64'h1);
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_pop_tag%0d", k), 64'(issue_tag), 64'(k));
      chk($sformatf("t3_pop_op%0d", k), 64'(issue_op), 64'h10 + 64'(k));
      tick;
    end
    chk("t3_fifo_empty", 64'(issue_valid), 64'h0);
    cmpl_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmpl_tag = TAG_W'(k); cmpl_result = 32'(k);
      tick;
      chk($sformatf("t3_rvalid%0d", k), 64'(apu_rvalid), 64'h1);
    end
    cmpl_valid = 1'b0;
    tick;
    chk("t3_busy_end", 64'(busy), 64'h0);

    // Tag wrap over nine request/complete pairs
    for (int k = 0; k < 9; k++) begin
      apu_req = 1'b1; apu_op = 6'(k);
      #1;
      chk($sformatf("t4_gnt%0d", k), 64'(apu_gnt), 64'h1);
      tick;
      apu_req = 1'b0;
      chk($sformatf("t4_tag%0d", k), 64'(issue_tag), 64'(k % 4));
      cmpl_valid = 1'b1; cmpl_tag = TAG_W'(k % 4); cmpl_result = 32'h111 * 32'(k);
      tick;
      cmpl_valid = 1'b0;
      chk($sformatf("t4_rvalid%0d", k), 64'(apu_rvalid), 64'h1);
      chk($sformatf("t4_result%0d", k), 64'(apu_result), 64'h111 * 64'(k));
      tick;
    end
    chk("t4_protocol_err", 64'(protocol_err), 64'h0);
    chk("t4_busy", 64'(busy), 64'h0);

    // Protocol error: wrong tag while expecting 0
    n_reset = 1'b0; tick; n_reset = 1'b1;
    apu_req = 1'b1; apu_op = 6'h2A;
    tick;
    apu_req = 1'b0;
    cmpl_valid = 1'b1; cmpl_tag = 2'd2; cmpl_result = 32'hDEAD;
    tick;
    cmpl_valid = 1'b0;
    chk("t5_no_rvalid", 64'(apu_rvalid), 64'h0);
    chk("t5_protocol_err", 64'(protocol_err), 64'h1);
    chk("t5_busy", 64'(busy), 64'h1);
    chk("t5_result_kept", 64'(apu_result), 64'h0);
    tick;
    chk("t5_err_sticky", 64'(protocol_err), 64'h1);
    cmpl_valid = 1'b1; cmpl_tag = 2'd0; cmpl_result = 32'hBEEF;
    tick;
    cmpl_valid = 1'b0;
    chk("t5_good_rvalid", 64'(apu_rvalid), 64'h1);
    chk("t5_good_result", 64'(apu_result), 64'hBEEF);
    tick;
    chk("t5_busy_end", 64'(busy), 64'h0);
    chk("t5_err_still", 64'(protocol_err), 64'h1);

    // Reset in the middle of activity
    issue_ready = 1'b0;
    apu_req = 1'b1;
    tick; tick; tick;
    cmpl_valid = 1'b1; cmpl_tag = 2'd1; cmpl_result = 32'h77;
    tick;
    cmpl_valid = 1'b0;
    chk("t6_rvalid_before", 64'(apu_rvalid), 64'h1);
    chk("t6_busy_before", 64'(busy), 64'h1);
    n_reset = 1'b0;
    #1;
    chk("t6_busy_rst", 64'(busy), 64'h0);
    chk("t6_issue_valid_rst", 64'(issue_valid), 64'h0);
    chk("t6_rvalid_rst", 64'(apu_rvalid), 64'h0);
    chk("t6_result_rst", 64'(apu_result), 64'h0);
    chk("t6_perr_rst", 64'(protocol_err), 64'h0);
    chk("t6_gnt_rst", 64'(apu_gnt), 64'h0);
    apu_req = 1'b0;
    tick;
    n_reset = 1'b1; issue_ready = 1'b1; apu_req = 1'b1; apu_op = 6'h3F;
    #1;
    chk("t6_gnt_after", 64'(apu_gnt), 64'h1);
    tick;
    apu_req = 1'b0;
    chk("t6_issue_valid_after", 64'(issue_valid), 64'h1);
    chk("t6_tag_after", 64'(issue_tag), 64'h0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
